// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the scan-chain controller.
// Imported by scan_ctrl and scan_word_packer.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FREEZE,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  // Number of host words needed to carry len chain bits.
  function automatic int nwords(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_word_packer.sv
// Serial-to-word assembly with a one-word valid/ready holding stage.
// Bit 0 of each word is the first bit received; short words are zero padded.
module scan_word_packer
  import scan_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              bit_in,
  input  logic              last,
  output logic              room,
  output logic              drained,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data
);

  localparam int PW = cnt_w(WORD_W);

  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] hold_q;
  logic [WORD_W-1:0] word_d;
  logic [PW-1:0]     pos_q;
  logic              full_q;
  logic              valid_q;
  logic              take;
  logic              free;
  logic              done_w;
  logic              move;
  logic              load_new;

  // Merge the incoming bit into the partial word and decide where it goes.
  always_comb begin
    word_d = asm_q;
    for (int i = 0; i < WORD_W; i++) begin
      if (pos_q == PW'(i)) word_d[i] = bit_in;
    end
    take     = valid_q & out_ready;
    free     = ~valid_q | out_ready;
    done_w   = shift & (last | (pos_q == PW'(WORD_W - 1)));
    move     = full_q & free;
    load_new = done_w & free;
  end

  // Assembly register, completed-word flag and holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q   <= '0;
      hold_q  <= '0;
      pos_q   <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (move) begin
      hold_q  <= asm_q;
      valid_q <= 1'b1;
      full_q  <= 1'b0;
      asm_q   <= '0;
    end else if (load_new) begin
      hold_q  <= word_d;
      valid_q <= 1'b1;
      asm_q   <= '0;
      pos_q   <= '0;
    end else begin
      if (take) valid_q <= 1'b0;
      if (done_w) begin
        asm_q  <= word_d;
        full_q <= 1'b1;
        pos_q  <= '0;
      end else if (shift) begin
        asm_q <= word_d;
        pos_q <= pos_q + PW'(1);
      end
    end
  end

  assign room      = ~full_q;
  assign drained   = ~full_q & free;
  assign out_valid = valid_q;
  assign out_data  = hold_q;

endmodule

// File: rtl/scan_ctrl.sv
// Scan-chain controller: freezes the design, shifts the chain out into
// host words and shifts restore data or the recirculated state back in.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_restore,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              dut_clk_en,
  output logic              scan_enable,
  output logic              scan_in,
  input  logic              scan_out,
  output logic              busy,
  output logic              done
);

  localparam int NW = nwords(CHAIN_LEN, WORD_W);
  localparam int BW = cnt_w(CHAIN_LEN);
  localparam int RW = cnt_w(WORD_W);
  localparam int TW = cnt_w(NW);

  state_t            state_q;
  state_t            state_d;
  logic              restore_q;
  logic [BW-1:0]     bcnt_q;
  logic [WORD_W-1:0] rdat_q;
  logic [RW-1:0]     rbits_q;
  logic [TW-1:0]     taken_q;

  logic              in_shift;
  logic              have_bits;
  logic              room;
  logic              drained;
  logic              shift;
  logic              last;
  logic              load;

  // Shift qualification and restore-word load strobe.
  always_comb begin
    in_shift  = (state_q == SHIFT);
    have_bits = (rbits_q != '0);
    last      = (bcnt_q == BW'(CHAIN_LEN - 1));
    shift     = in_shift & room & (~restore_q | have_bits);
    load      = in_shift & restore_q & ~have_bits
              & (taken_q != TW'(NW)) & in_valid;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = FREEZE;
      FREEZE:  state_d = SHIFT;
      SHIFT:   if (shift && last) state_d = DRAIN;
      DRAIN:   if (drained) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin-level outputs decoded from state and the shift strobe.
  always_comb begin
    cmd_ready   = (state_q == IDLE);
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    scan_enable = in_shift;
    dut_clk_en  = (state_q == IDLE) | shift;
    in_ready    = load;
    scan_in     = 1'b0;
    if (in_shift) scan_in = restore_q ? rdat_q[0] : scan_out;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Command latch, bit counter and restore unpacker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      restore_q <= 1'b0;
      bcnt_q    <= '0;
      rdat_q    <= '0;
      rbits_q   <= '0;
      taken_q   <= '0;
    end else begin
      if (state_q == IDLE && cmd_valid) restore_q <= cmd_restore;
      if (state_q == FREEZE) begin
        bcnt_q  <= '0;
        rbits_q <= '0;
        taken_q <= '0;
      end else begin
        if (shift) bcnt_q <= bcnt_q + BW'(1);
        if (load) begin
          rdat_q  <= in_data;
          rbits_q <= RW'(WORD_W);
          taken_q <= taken_q + TW'(1);
        end else if (shift && restore_q) begin
          rdat_q  <= rdat_q >> 1;
          rbits_q <= rbits_q - RW'(1);
        end
      end
    end
  end

  scan_word_packer #(
    .WORD_W(WORD_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .shift    (shift),
    .bit_in   (scan_out),
    .last     (last),
    .room     (room),
    .drained  (drained),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl: 20/8 main instance plus 8/8 and 1/8.
// Chain models sit at the far end of each DUT's scan pins.
module tb_scan_ctrl;

  logic clk;
  logic rst;

  // Main instance, CHAIN_LEN=20
  logic a_cmd_valid, a_cmd_ready, a_cmd_restore;
  logic a_in_valid, a_in_ready;
  logic [7:0] a_in_data, a_out_data;
  logic a_out_valid, a_out_ready;
  logic a_dut_clk_en, a_scan_enable, a_scan_in, a_scan_out;
  logic a_busy, a_done;
  logic [19:0] a_chain, a_load_val;
  logic a_load;

  // Small instances, CHAIN_LEN=8 and 1, sharing command pins
  logic s_cmd_valid;
  logic b_cmd_ready, b_in_ready, b_out_valid, b_clk_en, b_se, b_si, b_so;
  logic b_busy, b_done;
  logic [7:0] b_out_data, b_chain, b_load_val;
  logic c_cmd_ready, c_in_ready, c_out_valid, c_clk_en, c_se, c_si, c_so;
  logic c_busy, c_done;
  logic [7:0] c_out_data;
  logic c_chain, c_load_val;
  logic s_load;

  scan_ctrl #(.CHAIN_LEN(20), .WORD_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_restore(a_cmd_restore),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data),
    .dut_clk_en(a_dut_clk_en), .scan_enable(a_scan_enable),
    .scan_in(a_scan_in), .scan_out(a_scan_out),
    .busy(a_busy), .done(a_done)
  );

  scan_ctrl #(.CHAIN_LEN(8), .WORD_W(8)) dut_b (
    .clk(clk), .rst(rst),
    .cmd_valid(s_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_restore(1'b0),
    .in_valid(1'b0), .in_ready(b_in_ready), .in_data(8'h00),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
    .dut_clk_en(b_clk_en), .scan_enable(b_se),
    .scan_in(b_si), .scan_out(b_so),
    .busy(b_busy), .done(b_done)
  );

  scan_ctrl #(.CHAIN_LEN(1), .WORD_W(8)) dut_c (
    .clk(clk), .rst(rst),
    .cmd_valid(s_cmd_valid), .cmd_ready(c_cmd_ready),
    .cmd_restore(1'b0),
    .in_valid(1'b0), .in_ready(c_in_ready), .in_data(8'h00),
    .out_valid(c_out_valid), .out_ready(1'b1), .out_data(c_out_data),
    .dut_clk_en(c_clk_en), .scan_enable(c_se),
    .scan_in(c_si), .scan_out(c_so),
    .busy(c_busy), .done(c_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Chain models: tail bit feeds scan_out, shift on clk_en & scan_enable
  always_ff @(posedge clk) begin
    if (a_load) a_chain <= a_load_val;
    else if (a_dut_clk_en && a_scan_enable)
      a_chain <= {a_scan_in, a_chain[19:1]};
    if (s_load) begin
      b_chain <= b_load_val;
      c_chain <= c_load_val;
    end else begin
      if (b_clk_en && b_se) b_chain <= {b_si, b_chain[7:1]};
      if (c_clk_en && c_se) c_chain <= c_si;
    end
  end

  assign a_scan_out = a_chain[0];
  assign b_so = b_chain[0];
  assign c_so = c_chain;

  typedef struct {
    logic [19:0] preset;
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [7:0]  w2;
  } vec_t;

  vec_t vecs[5];

  int errors = 0;
  int checks = 0;
  logic [7:0] expa[$];
  logic [7:0] expb[$];
  logic [7:0] expc[$];
  logic [7:0] feed[$];
  int a_cyc = 999;
  int a_first_shift, a_shifts, a_done_n, a_done_cyc;
  int a_in_n, a_stall_n, a_gap, gap_len, a_gap_shifts;
  int b_done_n, c_done_n;
  bit a_blk_on;
  int a_blk_cnt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, inout logic [7:0] q[$],
                         input logic [7:0] act);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected word %0h", name, act);
    end else begin
      chk(name, act, q.pop_front());
    end
  endtask

  function automatic logic [7:0] wd(input logic [19:0] v, input int i);
    logic [19:0] t;
    t = v >> (8 * i);
    return t[7:0];
  endfunction

  task automatic chk_reset(input string name);
    chk(name,
        {a_cmd_ready, a_in_ready, a_out_valid, a_out_data,
         a_dut_clk_en, a_scan_enable, a_scan_in, a_busy, a_done},
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  // One clock: sample just before the edge, drive just after it.
  task automatic tick();
    bit popped;
    popped = 0;
    #1;
    if (a_cmd_valid && a_cmd_ready) begin
      a_cyc = 0;
      a_first_shift = -1;
    end else a_cyc++;
    if (a_dut_clk_en && a_scan_enable) begin
      a_shifts++;
      if (a_first_shift < 0) a_first_shift = a_cyc;
      if (a_gap > 0) a_gap_shifts++;
    end
    if (a_scan_enable && !a_dut_clk_en) a_stall_n++;
    if (a_done) begin
      a_done_n++;
      a_done_cyc = a_cyc;
    end
    if (a_out_valid && a_out_ready) pop_chk("a_word", expa, a_out_data);
    if (a_in_ready) begin
      chk("a_in_ready_needs_valid", a_in_valid, 1);
      a_in_n++;
      if (feed.size() > 0) void'(feed.pop_front());
      popped = 1;
    end
    if (a_blk_on && a_out_valid) a_blk_cnt++;
    if (b_out_valid) pop_chk("b_word", expb, b_out_data);
    if (c_out_valid) pop_chk("c_word", expc, c_out_data);
    if (b_done) b_done_n++;
    if (c_done) c_done_n++;
    @(posedge clk);
    #1;
    if (popped && gap_len > 0 && a_in_n == 1) a_gap = gap_len;
    else if (a_gap > 0) a_gap--;
    a_in_valid = (feed.size() > 0) && (a_gap == 0);
    a_in_data = (feed.size() > 0) ? feed[0] : 8'h00;
    if (a_blk_on && a_blk_cnt >= 10) a_blk_on = 0;
    a_out_ready = !a_blk_on;
    @(negedge clk);
  endtask

  task automatic load_a(input logic [19:0] v);
    a_load_val = v;
    a_load = 1;
    tick();
    a_load = 0;
  endtask

  task automatic a_op(input bit restore, input logic [7:0] w0,
                      input logic [7:0] w1, input logic [7:0] w2);
    int n;
    expa.push_back(w0);
    expa.push_back(w1);
    expa.push_back(w2);
    a_shifts = 0;
    a_done_n = 0;
    a_in_n = 0;
    a_stall_n = 0;
    a_gap_shifts = 0;
    a_done_cyc = -1;
    a_cmd_restore = restore;
    a_cmd_valid = 1;
    tick();
    a_cmd_valid = 0;
    n = 0;
    while (a_done_n == 0 && n < 300) begin
      tick();
      n++;
    end
    tick();
    chk("a_done_once", a_done_n, 1);
    chk("a_shift_edges", a_shifts, 20);
    chk("a_words_left", expa.size(), 0);
    chk("a_idle_after", {a_cmd_ready, a_busy}, 2'b10);
    expa.delete();
  endtask

  task automatic run_small(input logic [7:0] bv, input logic cv);
    int n;
    int bd;
    int cd;
    b_load_val = bv;
    c_load_val = cv;
    s_load = 1;
    tick();
    s_load = 0;
    expb.push_back(bv);
    expc.push_back({7'b0, cv});
    bd = b_done_n;
    cd = c_done_n;
    s_cmd_valid = 1;
    tick();
    s_cmd_valid = 0;
    n = 0;
    while ((b_done_n == bd || c_done_n == cd) && n < 100) begin
      tick();
      n++;
    end
    tick();
    chk("b_done_once", b_done_n - bd, 1);
    chk("c_done_once", c_done_n - cd, 1);
    chk("b_words_left", expb.size(), 0);
    chk("c_words_left", expc.size(), 0);
    chk("b_chain_kept", b_chain, bv);
    chk("c_chain_kept", c_chain, cv);
    expb.delete();
    expc.delete();
  endtask

  initial begin
    vecs[0] = '{20'hA5C3F, 8'h3F, 8'h5C, 8'h0A};
    vecs[1] = '{20'h00000, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{20'hFFFFF, 8'hFF, 8'hFF, 8'h0F};
    vecs[3] = '{20'h80001, 8'h01, 8'h00, 8'h08};
    vecs[4] = '{20'h12345, 8'h45, 8'h23, 8'h01};

    rst = 1;
    a_cmd_valid = 0;
    a_cmd_restore = 0;
    a_in_valid = 0;
    a_in_data = 0;
    a_out_ready = 1;
    a_load = 0;
    a_load_val = 0;
    s_cmd_valid = 0;
    s_load = 0;
    b_load_val = 0;
    c_load_val = 0;
    a_gap = 0;
    gap_len = 0;
    a_blk_on = 0;
    a_blk_cnt = 0;
    b_done_n = 0;
    c_done_n = 0;
    a_first_shift = -1;

    @(negedge clk);
    chk_reset("reset_values");
    tick();
    tick();
    rst = 0;
    tick();
    chk_reset("idle_after_reset");

    // Table of dumps with known expected words
    for (int i = 0; i < 5; i++) begin
      load_a(vecs[i].preset);
      a_op(0, vecs[i].w0, vecs[i].w1, vecs[i].w2);
      chk("dump_chain_kept", a_chain, vecs[i].preset);
      chk("dump_first_shift", a_first_shift, 2);
      chk("dump_done_cycle", a_done_cyc, 23);
    end

    // Restore 12,34,05 with a fourth word on offer, then dump it back
    load_a(20'hA5C3F);
    feed = '{8'h12, 8'h34, 8'h05, 8'h77};
    a_op(1, 8'h3F, 8'h5C, 8'h0A);
    chk("restore_in_pulses", a_in_n, 3);
    chk("restore_extra_kept", feed.size(), 1);
    chk("restore_chain", a_chain, 20'h53412);
    feed.delete();
    tick();
    chk("in_valid_dropped", a_in_valid, 0);
    a_op(0, 8'h12, 8'h34, 8'h05);
    chk("roundtrip_chain", a_chain, 20'h53412);

    // Restore with a long in_valid gap after the first word
    gap_len = 15;
    feed = '{8'h9A, 8'hBC, 8'h0D};
    a_op(1, wd(a_chain, 0), wd(a_chain, 1), wd(a_chain, 2));
    chk("gap_shifts", a_gap_shifts, 8);
    chk("gap_chain", a_chain, 20'hDBC9A);
    chk("gap_in_pulses", a_in_n, 3);
    gap_len = 0;
    feed.delete();

    // Host back-pressure: word 0 held unaccepted for 10 cycles
    load_a(20'hA5C3F);
    a_blk_on = 1;
    a_blk_cnt = 0;
    a_out_ready = 0;
    a_op(0, 8'h3F, 8'h5C, 8'h0A);
    chk("stall_seen", a_stall_n > 0, 1);
    chk("stall_chain_kept", a_chain, 20'hA5C3F);
    a_blk_on = 0;
    a_out_ready = 1;

    // Reset in the middle of SHIFT; cmd_valid held high while busy
    load_a(20'hA5C3F);
    a_cmd_restore = 0;
    a_cmd_valid = 1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    chk("busy_ignores_cmd", {a_cmd_ready, a_busy, a_cyc}, {1'b0, 1'b1, 32'd8});
    chk("mid_shift", a_scan_enable, 1);
    a_cmd_valid = 0;
    rst = 1;
    #1;
    chk_reset("abort_values");
    tick();
    chk_reset("abort_values_next");
    rst = 0;
    expa.delete();
    tick();
    load_a(20'h5A5A5);
    a_op(0, 8'hA5, 8'hA5, 8'h05);
    chk("after_abort_chain", a_chain, 20'h5A5A5);

    // Single-word chains: 8 bits and 1 bit with zero padding
    run_small(8'hC3, 1'b1);
    run_small(8'h5A, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
# scan_ctrl

Scan-chain controller sitting at the far end of an inserted scan chain. It freezes the design clock and shifts the whole chain out, packing the captured state into host words. In the same pass it shifts either host-supplied words (restore) or the recirculated state (non-destructive dump) back in. It bridges the host's valid/ready word streams and the design's scan_enable/scan_in/scan_out/clock-enable pins.

## Interface
- CHAIN_LEN, 20, number of scan flops in the chain (≥1)
- WORD_W, 8, host word width (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  start request
- cmd_ready  out  1  high only in IDLE
- cmd_restore  in  1  0 = dump (recirculate), 1 = restore from in_data
- in_valid  in  1  restore word available
- in_ready  out  1  restore word consumed this cycle
- in_data  in  WORD_W  restore word, bit 0 shifted in first
- out_valid  out  1  captured word available
- out_ready  in  1  host accepts captured word
- out_data  out  WORD_W  captured word, bit 0 shifted out first
- dut_clk_en  out  1  design clock enable; a chain shift occurs on clk edges where dut_clk_en & scan_enable
- scan_enable  out  1  chain in shift mode
- scan_in  out  1  serial data into chain head
- scan_out  in  1  serial data from chain tail
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse when the operation completes

## Operation
- NWORDS = ceil(CHAIN_LEN/WORD_W). Bit counter width is $clog2(CHAIN_LEN+1).
- States:
  - IDLE: cmd_valid&cmd_ready latches cmd_restore and goes to FREEZE.
  - FREEZE: one cycle with dut_clk_en=0 and scan_enable=0, then go to SHIFT.
  - SHIFT: scan_enable=1 throughout. When bit counter reaches CHAIN_LEN, go to DRAIN.
  - DRAIN: scan_enable=0, dut_clk_en=0. Wait until the last word is accepted, then go to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- Shift condition in SHIFT: the assembly register has room AND (dump, or the restore word register holds bits).
  - dut_clk_en=1 only on shift cycles; 0 on all other non-IDLE cycles.
- Bit k (k = 0..CHAIN_LEN-1) sampled from scan_out goes to out word k/WORD_W, bit k%WORD_W.
  - A word is complete after WORD_W bits, or after the final bit; the final word's unused upper bits are 0.
- scan_in for bit k:
  - restore: in word k/WORD_W, bit k%WORD_W.
  - dump: scan_out (combinational recirculation).
- Restore words are consumed in order. in_ready pulses when a word is loaded into the internal restore register. This happens when the register is empty in SHIFT and fewer than NWORDS words have been taken. Extra in_valid is ignored.
- A completed word moves to the holding register (out_valid) if it is empty. Otherwise shifting stalls.
- Round trip: a dump immediately after a restore returns the restored words unchanged.
- IDLE: dut_clk_en=1, scan_enable=0, scan_in=0.

## Timing
- Reset values: cmd_ready=1, in_ready=0, out_valid=0, out_data=0, dut_clk_en=1, scan_enable=0, scan_in=0, busy=0, done=0. The FSM returns to IDLE.
- Reset mid-operation aborts immediately with the same values. Chain contents are then undefined.
- Latency: the accepted command is in FREEZE next cycle. With no stalls, the first shift is 2 cycles after acceptance.
- out_valid holds with out_data stable until out_ready. Completing a word and the host accepting in the same cycle → no stall.
- Unstalled, the full dump takes 1 + CHAIN_LEN + (words-to-drain) + 1 cycles. Throughput is 1 bit/cycle.
- cmd_valid while busy is ignored (cmd_ready=0).

## Structure
- scan_pkg: state enum (IDLE, FREEZE, SHIFT, DRAIN, DONE), NWORDS function, counter-width localparam helper.
- Sub-module scan_word_packer: serial-to-word assembly plus holding register with valid/ready. Instantiated once.
- The restore unpacker is simple enough to stay inline.

## Test plan
- Dump, CHAIN_LEN=20, WORD_W=8, chain model preset to 0xA5C3F, out_ready=1 → words 0x3F, 0x5C, 0x0A in order. Exactly 20 shift edges. Chain unchanged afterwards. done pulses once.
- Restore 0x12, 0x34, 0x05 then dump → dump returns 0x12, 0x34, 0x05. Exactly 3 in_ready pulses. A 4th offered word is not consumed.
- Dump with out_ready low for 10 cycles after word 0 → shifting stalls (dut_clk_en=0, scan_enable=1). Chain position is preserved. Data is identical to the unstalled run.
- Restore with in_valid gaps → no shift edge while the restore register is empty. Final chain = supplied data.
- Assert rst midway through SHIFT → next cycle all outputs at reset values. A fresh command then completes normally.
- CHAIN_LEN=8, WORD_W=8 and CHAIN_LEN=1 → single word. Padding is correct: bit 0 only for the 1-flop chain.
